irq_controller: RTL

//  Prioritising interrupt controller for the 16-bit MIPS pipeline. Collects N_SRC

---
 rtl/mips_pkg.sv | 14 +
 rtl/irq_prio_enc.sv | 19 +
 rtl/irq_controller.sv | 96 +++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared FSM encodings and config-port address map for the interrupt controller
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

    localparam logic [1:0] CFG_MASK   = 2'd0;
    localparam logic [1:0] CFG_PEND   = 2'd1;
    localparam logic [1:0] CFG_STATUS = 2'd2;

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: combinational fixed-priority encoder, lowest set index wins
module irq_prio_enc #(
    parameter int N = 4,
    parameter int W = 4
) (
    input  logic [N-1:0] vec,
    output logic         valid,
    output logic [W-1:0] idx
);

    // scan from the top down so the lowest set bit is the last to overwrite idx
    always_comb begin
        valid = |vec;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--)
            if (vec[i]) idx = W'(i);
    end

endmodule

// File: rtl/irq_controller.sv
// irq_controller: edge-latched, masked, fixed-priority interrupt issue with EOI handshake
module irq_controller
    import mips_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int ID_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             stall,
    input  logic             eoi,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [15:0]      cfg_wdata,
    output logic [15:0]      cfg_rdata,
    output logic             interrupt,
    output logic [ID_W-1:0]  irq_id,
    output logic             in_service
);

    irq_state_e       state_q, state_d;
    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic             insvc_q, insvc_d;
    logic [15:0]      rdata_q, rdata_d;
    logic [N_SRC-1:0] cand, w1c, clr;
    logic [ID_W-1:0]  sel;
    logic             cand_valid, issue;
    logic [ID_W+2:0]  status;
    logic             unused_wdata;

    assign cand         = pend_q & mask_q;
    assign issue        = (state_q == IDLE) && cand_valid && !stall;
    assign status       = {insvc_q, state_q, id_q};
    assign unused_wdata = ^cfg_wdata;

    irq_prio_enc #(.N(N_SRC), .W(ID_W)) u_enc (
        .vec   (cand),
        .valid (cand_valid),
        .idx   (sel)
    );

    // state and datapath registers; reset overrides eoi and config writes
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
            id_q    <= '0;
            insvc_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= irq_src;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            id_q    <= id_d;
            insvc_q <= insvc_d;
            rdata_q <= rdata_d;
        end
    end

    // next state: stall only gates leaving IDLE, ISSUE lasts one cycle, SERVICE waits for eoi
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = issue ? ISSUE : IDLE;
            ISSUE:   state_d = SERVICE;
            SERVICE: state_d = eoi ? IDLE : SERVICE;
            default: state_d = IDLE;
        endcase
    end

    // pending/mask/id/status updates and registered read mux; a new edge beats W1C and issue-clear
    always_comb begin
        w1c     = (cfg_we && cfg_addr == CFG_PEND) ? cfg_wdata[N_SRC-1:0] : '0;
        clr     = issue ? (N_SRC'(1) << sel) : '0;
        pend_d  = (pend_q & ~w1c & ~clr) | (irq_src & ~src_q);
        mask_d  = (cfg_we && cfg_addr == CFG_MASK) ? cfg_wdata[N_SRC-1:0] : mask_q;
        id_d    = issue ? sel : id_q;
        insvc_d = issue ? 1'b1 : (state_q == SERVICE && eoi) ? 1'b0 : insvc_q;
        rdata_d = cfg_addr == CFG_MASK   ? 16'(mask_q) :
                  cfg_addr == CFG_PEND   ? 16'(pend_q) :
                  cfg_addr == CFG_STATUS ? 16'(status) : 16'h0000;
    end

    assign interrupt  = state_q == ISSUE;
    assign irq_id     = id_q;
    assign in_service = insvc_q;
    assign cfg_rdata  = rdata_q;

endmodule
